sisc_ctrl_fsm: RTL and testbench
================================

SISC_CTRL_FSM -- requirements
Module: sisc_ctrl_fsm

Interface
REQ-001 Parameter ALU_OP_W, default 2: alu_op width; ALU_OP_W of 2 or more SHALL be supported.
REQ-002 Parameter CNT_W, default 16: retired-instruction counter width.
REQ-003 Parameter MEM_HANDSHAKE, default 1: 1 means MEM waits on mem_rdy; 0 means mem_rdy is ignored and MEM lasts 1 cycle.
REQ-004 clk  in  1  single clock; all state changes on posedge.
REQ-005 rst_f  in  1  reset, asynchronous, active-low.
REQ-006 opcode  in  4  IR[31:28]; stable from the cycle after FETCH until the next FETCH.
REQ-007 mm  in  4  IR mode/mask field.
REQ-008 stat  in  4  ALU status register.
REQ-009 mem_rdy  in  1  data memory completion.
REQ-010 pc_rst, pc_write, pc_sel, br_sel, ir_load  out  1 each  PC/IR control.
REQ-011 rf_we, wb_sel, rd_sel, dm_we  out  1 each  datapath control.
REQ-012 alu_op  out  ALU_OP_W  ALU function select.
REQ-013 halted  out  1  registered; high while in HALT.
REQ-014 illegal  out  1  registered one-cycle pulse on an undefined opcode.
REQ-015 retired  out  CNT_W  count of completed instructions.

Function
REQ-016 States SHALL be START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
REQ-017 State sequence SHALL be START0->START1->FETCH->DECODE->EXECUTE->MEM->WRITEBACK->FETCH, except where REQ-018 and REQ-019 apply.
REQ-018 DECODE with opcode 15 (HLT) SHALL go to HALT; HALT SHALL be left only by reset.
REQ-019 In MEM, for LOD(1) or STR(2) with MEM_HANDSHAKE=1, the FSM SHALL hold until mem_rdy=1, then advance on that edge.
REQ-020 Non-memory instruction latency SHALL be exactly 5 cycles, FETCH to FETCH.
REQ-021 Memory instruction latency SHALL be 5 + N cycles, where N is the number of MEM cycles with mem_rdy=0.
REQ-022 Opcodes other than 0, 1, 2, 4, 5, 6, 8 and 15 SHALL execute as NOOP, with illegal pulsing the cycle after DECODE.
REQ-023 Outputs other than halted, illegal and retired SHALL be combinational from state, opcode, mm and stat, and SHALL be 0 unless listed below.
REQ-024 In START0 and START1: pc_rst=1.
REQ-025 In FETCH: ir_load=1, pc_write=1, pc_sel=0 (PC+1).
REQ-026 In DECODE, a branch is taken when:
  - BRA(4) or BRR(5): (mm & stat) != 0
  - BNE(6): (mm & stat) == 0
REQ-027 On a taken branch in DECODE: pc_write=1, pc_sel=1, br_sel=1 for BRR, br_sel=0 for BRA/BNE.
REQ-028 In EXECUTE, alu_op SHALL be:
  - ALU(8) with mm==8: 1 (immediate)
  - ALU(8), other mm: 0 (register)
  - LOD/STR: 2 (address)
  - all others: 0
REQ-029 rd_sel=1 in EXECUTE and MEM for STR; 0 otherwise.
REQ-030 dm_we=1 in MEM for STR only, and only in the cycle the FSM advances.
REQ-031 In WRITEBACK: rf_we=1 for ALU and LOD; wb_sel=1 for LOD, 0 for ALU.
REQ-032 retired SHALL increment on each WRITEBACK->FETCH edge, saturate at all-ones, and never increment in HALT.
REQ-033 A mem_rdy pulse outside MEM SHALL be ignored.

Reset
REQ-034 rst_f low SHALL force the following immediately, regardless of clk or current state (including MEM waits and HALT): state=START0, halted=0, illegal=0, retired=0.
REQ-035 With the FSM in START0, pc_rst SHALL read 1 and all other combinational outputs 0.
REQ-036 After rst_f rises, the first FETCH SHALL occur on the 2nd posedge.

Structure
REQ-037 Package sisc_pkg SHALL hold:
  - opcode constants (NOOP, LOD, STR, BRA, BRR, BNE, ALU, HLT)
  - AM_IMM=8
  - state enumeration
  - alu_op codes
REQ-038 The branch-condition evaluation SHALL be a sub-module sisc_br_eval (opcode, mm, stat -> taken); everything else SHALL be flat.

Verification
REQ-039 Reset, then ALU opcode=8, mm=0: FETCH at cycle 2 and again at cycle 7; rf_we=1 only in cycle 6; retired=1.
REQ-040 LOD with mem_rdy low for 3 MEM cycles: MEM lasts 4 cycles; wb_sel=1 and rf_we=1 in WRITEBACK; latency 8 cycles.
REQ-041 BRR with mm=4'b0010, stat=4'b0010: DECODE asserts pc_write=1, pc_sel=1, br_sel=1. Same with stat=0: pc_write=0 in DECODE. BNE with stat=0: taken, with br_sel=0.
REQ-042 STR, with rst_f dropped mid-MEM wait: dm_we never asserted; state=START0 and retired=0 without a clock edge.
REQ-043 HLT: halted=1 after DECODE; FSM stays in HALT for 20 cycles with mem_rdy toggling; retired unchanged. Opcode 4'hB: illegal pulses once; 5-cycle NOOP.
REQ-044 CNT_W=3: 9 NOOPs leave retired=7 (saturated).

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared opcode constants, FSM state encoding and ALU select codes for the SISC controller.
package sisc_pkg;

    localparam logic [3:0] NOOP = 4'd0;
    localparam logic [3:0] LOD  = 4'd1;
    localparam logic [3:0] STR  = 4'd2;
    localparam logic [3:0] BRA  = 4'd4;
    localparam logic [3:0] BRR  = 4'd5;
    localparam logic [3:0] BNE  = 4'd6;
    localparam logic [3:0] ALU  = 4'd8;
    localparam logic [3:0] HLT  = 4'd15;

    localparam logic [3:0] AM_IMM = 4'd8;

    localparam int ALU_OP_REG  = 0;
    localparam int ALU_OP_IMM  = 1;
    localparam int ALU_OP_ADDR = 2;

    typedef enum logic [2:0] {
        START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            NOOP, LOD, STR, BRA, BRR, BNE, ALU, HLT: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sisc_ctrl_fsm_if.sv
// Instruction/status inputs and datapath control outputs of the SISC controller.
interface sisc_ctrl_fsm_if #(
    parameter int ALU_OP_W = 2,
    parameter int CNT_W    = 16
);
    logic [3:0]          opcode;
    logic [3:0]          mm;
    logic [3:0]          stat;
    logic                mem_rdy;
    logic                pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic                rf_we, wb_sel, rd_sel, dm_we;
    logic [ALU_OP_W-1:0] alu_op;
    logic                halted;
    logic                illegal;
    logic [CNT_W-1:0]    retired;

    modport master (
        output opcode, mm, stat, mem_rdy,
        input  pc_rst, pc_write, pc_sel, br_sel, ir_load,
        input  rf_we, wb_sel, rd_sel, dm_we, alu_op, halted, illegal, retired
    );

    modport slave (
        input  opcode, mm, stat, mem_rdy,
        output pc_rst, pc_write, pc_sel, br_sel, ir_load,
        output rf_we, wb_sel, rd_sel, dm_we, alu_op, halted, illegal, retired
    );
endinterface

// File: rtl/sisc_br_eval.sv
// Branch condition: BRA/BRR taken when any masked status bit is set, BNE when none is.
module sisc_br_eval
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken
);
    always_comb begin
        taken = 1'b0;
        case (opcode)
            BRA, BRR: taken = |(mm & stat);
            BNE:      taken = ~|(mm & stat);
            default:  taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/sisc_ctrl_fsm.sv
// Multi-cycle SISC control FSM: sequences fetch/decode/execute/mem/writeback and counts retirements.
module sisc_ctrl_fsm
    import sisc_pkg::*;
#(
    parameter int ALU_OP_W      = 2,
    parameter int CNT_W         = 16,
    parameter int MEM_HANDSHAKE = 1
) (
    input  logic            clk,
    input  logic            rst_f,
    sisc_ctrl_fsm_if.slave  bus
);
    state_t              state_reg, state_next;
    logic                halted_reg, illegal_reg;
    logic [CNT_W-1:0]    retired_reg;
    logic                taken, is_mem, mem_done;
    logic                pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic                rf_we, wb_sel, rd_sel, dm_we;
    logic [ALU_OP_W-1:0] alu_op;

    sisc_br_eval u_br_eval (
        .opcode (bus.opcode),
        .mm     (bus.mm),
        .stat   (bus.stat),
        .taken  (taken)
    );

    assign is_mem   = (bus.opcode == LOD) || (bus.opcode == STR);
    // Without the handshake, MEM is always a single cycle.
    assign mem_done = (MEM_HANDSHAKE == 0) || !is_mem || bus.mem_rdy;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_reg   <= START0;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg   <= state_next;
            halted_reg  <= (state_next == HALT);
            illegal_reg <= (state_reg == DECODE) && !is_legal(bus.opcode);
            if (state_reg == WRITEBACK && retired_reg != '1)
                retired_reg <= retired_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_rst     = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        br_sel     = 1'b0;
        ir_load    = 1'b0;
        rf_we      = 1'b0;
        wb_sel     = 1'b0;
        rd_sel     = 1'b0;
        dm_we      = 1'b0;
        alu_op     = '0;
        case (state_reg)
            START0: begin
                pc_rst     = 1'b1;
                state_next = START1;
            end
            START1: begin
                pc_rst     = 1'b1;
                state_next = FETCH;
            end
            FETCH: begin
                ir_load    = 1'b1;
                pc_write   = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (taken) begin
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_sel   = (bus.opcode == BRR);
                end
                state_next = (bus.opcode == HLT) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                if (bus.opcode == ALU)
                    alu_op = (bus.mm == AM_IMM) ? ALU_OP_W'(ALU_OP_IMM) : ALU_OP_W'(ALU_OP_REG);
                else if (is_mem)
                    alu_op = ALU_OP_W'(ALU_OP_ADDR);
                rd_sel     = (bus.opcode == STR);
                state_next = MEM;
            end
            MEM: begin
                rd_sel = (bus.opcode == STR);
                if (mem_done) begin
                    dm_we      = (bus.opcode == STR);
                    state_next = WRITEBACK;
                end
            end
            WRITEBACK: begin
                rf_we      = (bus.opcode == ALU) || (bus.opcode == LOD);
                wb_sel     = (bus.opcode == LOD);
                state_next = FETCH;
            end
            HALT:    state_next = HALT;
            default: state_next = START0;
        endcase
    end

    assign bus.pc_rst   = pc_rst;
    assign bus.pc_write = pc_write;
    assign bus.pc_sel   = pc_sel;
    assign bus.br_sel   = br_sel;
    assign bus.ir_load  = ir_load;
    assign bus.rf_we    = rf_we;
    assign bus.wb_sel   = wb_sel;
    assign bus.rd_sel   = rd_sel;
    assign bus.dm_we    = dm_we;
    assign bus.alu_op   = alu_op;
    assign bus.halted   = halted_reg;
    assign bus.illegal  = illegal_reg;
    assign bus.retired  = retired_reg;
endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// Scoreboard bench for sisc_ctrl_fsm: per-instruction expectations from a behavioural model, checked at each instruction boundary.
module tb_sisc_ctrl_fsm;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    always #5 clk = ~clk;

    sisc_ctrl_fsm_if #(.ALU_OP_W(2), .CNT_W(16)) bus ();
    sisc_ctrl_fsm_if #(.ALU_OP_W(3), .CNT_W(3))  sbus ();

    sisc_ctrl_fsm #(.ALU_OP_W(2), .CNT_W(16), .MEM_HANDSHAKE(1)) dut (
        .clk(clk), .rst_f(rst_f), .bus(bus));
    sisc_ctrl_fsm #(.ALU_OP_W(3), .CNT_W(3), .MEM_HANDSHAKE(0)) dut_sat (
        .clk(clk), .rst_f(rst_f), .bus(sbus));

    typedef struct {
        int op, lat, dec_pcw, dec_pcsel, dec_brsel, alu_ex, n_alu;
        int n_rd, n_dm, dm_pos, n_rf, rf_pos, n_wb, n_ill;
        int n_pcw, n_pcsel, n_brsel, n_pcrst, ret;
    } rec_t;

    rec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tx_idx = 0;
    int   ret_model = 0;
    bit   mon_en = 1'b1;
    bit   str_watch = 1'b0;
    int   dm_seen = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    function automatic rec_t blank_rec();
        rec_t r;
        r.op = 0; r.lat = 0; r.dec_pcw = 0; r.dec_pcsel = 0; r.dec_brsel = 0;
        r.alu_ex = 0; r.n_alu = 0; r.n_rd = 0; r.n_dm = 0; r.dm_pos = -1;
        r.n_rf = 0; r.rf_pos = -1; r.n_wb = 0; r.n_ill = 0; r.n_pcw = 0;
        r.n_pcsel = 0; r.n_brsel = 0; r.n_pcrst = 0; r.ret = 0;
        return r;
    endfunction

    // Behavioural reference: what one instruction should look like from FETCH to the next boundary.
    function automatic rec_t model(input int op, input int mm, input int st, input int nw, input int ret_before);
        rec_t r = blank_rec();
        bit memop = (op == 1) || (op == 2);
        bit legal = (op inside {0, 1, 2, 4, 5, 6, 8, 15});
        bit taken = ((op == 4 || op == 5) && ((mm & st) != 0)) || (op == 6 && ((mm & st) == 0));
        r.op = op;
        if (op == 15) begin
            r.lat = 2; r.n_pcw = 1; r.ret = ret_before;
            return r;
        end
        r.lat       = 5 + (memop ? nw : 0);
        r.dec_pcw   = taken;
        r.dec_pcsel = taken;
        r.dec_brsel = taken && (op == 5);
        r.alu_ex    = (op == 8) ? ((mm == 8) ? 1 : 0) : (memop ? 2 : 0);
        r.n_alu     = (r.alu_ex != 0);
        r.n_rd      = (op == 2) ? 2 + nw : 0;
        r.n_dm      = (op == 2);
        r.dm_pos    = (op == 2) ? r.lat - 2 : -1;
        r.n_rf      = (op == 8 || op == 1);
        r.rf_pos    = r.n_rf ? r.lat - 1 : -1;
        r.n_wb      = (op == 1);
        r.n_ill     = !legal;
        r.n_pcw     = 1 + taken;
        r.n_pcsel   = taken;
        r.n_brsel   = r.dec_brsel;
        r.ret       = ret_before + 1;
        return r;
    endfunction

    // Drives one instruction; starts and ends at #1 after a posedge, first cycle is FETCH.
    task automatic run_instr(input int op, input int mm, input int st, input int nw);
        bit memop = (op == 1) || (op == 2);
        int lat = (op == 15) ? 2 : 5 + (memop ? nw : 0);
        if (mon_en) exp_q.push_back(model(op, mm, st, nw, ret_model));
        if (op != 15) ret_model++;
        bus.opcode = 4'(op);
        bus.mm     = 4'(mm);
        bus.stat   = 4'(st);
        for (int c = 0; c < lat; c++) begin
            if (memop && c >= 3 && c < 3 + nw) bus.mem_rdy = 1'b0;
            else if (memop && c == 3 + nw)     bus.mem_rdy = 1'b1;
            else                               bus.mem_rdy = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic close_tx(input rec_t o);
        rec_t e;
        string p;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL tx%0d boundary: got an unexpected instruction boundary, required none", tx_idx);
            return;
        end
        n_cmp--;
        e = exp_q.pop_front();
        p = $sformatf("tx%0d op%0d ", tx_idx, e.op);
        chk({p, "latency"},   o.lat,       e.lat);
        chk({p, "dec_pcw"},   o.dec_pcw,   e.dec_pcw);
        chk({p, "dec_pcsel"}, o.dec_pcsel, e.dec_pcsel);
        chk({p, "dec_brsel"}, o.dec_brsel, e.dec_brsel);
        chk({p, "ex_alu_op"}, o.alu_ex,    e.alu_ex);
        chk({p, "n_alu_op"},  o.n_alu,     e.n_alu);
        chk({p, "n_rd_sel"},  o.n_rd,      e.n_rd);
        chk({p, "n_dm_we"},   o.n_dm,      e.n_dm);
        chk({p, "dm_we_pos"}, o.dm_pos,    e.dm_pos);
        chk({p, "n_rf_we"},   o.n_rf,      e.n_rf);
        chk({p, "rf_we_pos"}, o.rf_pos,    e.rf_pos);
        chk({p, "n_wb_sel"},  o.n_wb,      e.n_wb);
        chk({p, "n_illegal"}, o.n_ill,     e.n_ill);
        chk({p, "n_pc_write"},o.n_pcw,     e.n_pcw);
        chk({p, "n_pc_sel"},  o.n_pcsel,   e.n_pcsel);
        chk({p, "n_br_sel"},  o.n_brsel,   e.n_brsel);
        chk({p, "n_pc_rst"},  o.n_pcrst,   e.n_pcrst);
        chk({p, "retired"},   o.ret,       e.ret);
        $display("tx %0d op=%0d lat=%0d retired=%0d", tx_idx, e.op, o.lat, o.ret);
        tx_idx++;
    endtask

    // Monitor: an instruction ends at the next FETCH (ir_load) or when halted rises.
    initial begin
        rec_t cur = blank_rec();
        int   ccyc = 0;
        bit   in_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (in_tx && (bus.ir_load || bus.halted)) begin
                    cur.lat = ccyc;
                    cur.ret = int'(bus.retired);
                    close_tx(cur);
                    in_tx = 1'b0;
                end
                if (bus.ir_load) begin
                    in_tx = 1'b1;
                    ccyc  = 0;
                    cur   = blank_rec();
                end
                if (in_tx) begin
                    if (ccyc == 1) begin
                        cur.dec_pcw   = bus.pc_write;
                        cur.dec_pcsel = bus.pc_sel;
                        cur.dec_brsel = bus.br_sel;
                    end
                    if (ccyc == 2) cur.alu_ex = int'(bus.alu_op);
                    cur.n_alu   += (bus.alu_op != 0);
                    cur.n_rd    += bus.rd_sel;
                    cur.n_dm    += bus.dm_we;
                    cur.n_rf    += bus.rf_we;
                    cur.n_wb    += bus.wb_sel;
                    cur.n_ill   += bus.illegal;
                    cur.n_pcw   += bus.pc_write;
                    cur.n_pcsel += bus.pc_sel;
                    cur.n_brsel += bus.br_sel;
                    cur.n_pcrst += bus.pc_rst;
                    if (bus.dm_we) cur.dm_pos = ccyc;
                    if (bus.rf_we) cur.rf_pos = ccyc;
                    ccyc++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (str_watch && bus.dm_we) dm_seen++;
        end
    end

    // Start-up sequence of the main instance after the first reset release.
    initial begin
        @(posedge rst_f);
        @(negedge clk);
        chk("start_c0_pc_rst", bus.pc_rst, 1);
        chk("start_c0_ir_load", bus.ir_load, 0);
        @(negedge clk);
        chk("start_c1_pc_rst", bus.pc_rst, 1);
        chk("start_c1_ir_load", bus.ir_load, 0);
        @(negedge clk);
        chk("start_c2_ir_load", bus.ir_load, 1);
        chk("start_c2_pc_rst", bus.pc_rst, 0);
    end

    // Narrow counter instance: NOOPs every 5 cycles, counter must stick at 7.
    initial begin
        @(posedge rst_f);
        repeat (32) @(posedge clk);
        #1 chk("sat_retired_after6", int'(sbus.retired), 6);
        repeat (15) @(posedge clk);
        #1 chk("sat_retired_after9", int'(sbus.retired), 7);
        repeat (5) @(posedge clk);
        #1 chk("sat_retired_after10", int'(sbus.retired), 7);
        chk("sat_fetch_c52", sbus.ir_load, 1);
        sbus.opcode = 4'd1;
        repeat (4) @(posedge clk);
        #1 chk("sat_lod_wb_sel", sbus.wb_sel, 1);
        @(posedge clk);
        #1 chk("sat_lod_no_handshake_fetch", sbus.ir_load, 1);
    end

    initial begin
        int op, mm, st, nw;
        bus.opcode = '0; bus.mm = '0; bus.stat = '0; bus.mem_rdy = 1'b0;
        sbus.opcode = '0; sbus.mm = '0; sbus.stat = '0; sbus.mem_rdy = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc_rst", bus.pc_rst, 1);
        chk("rst_pc_write", bus.pc_write, 0);
        chk("rst_ir_load", bus.ir_load, 0);
        chk("rst_alu_op", int'(bus.alu_op), 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_retired", int'(bus.retired), 0);
        chk("rst_sat_pc_rst", sbus.pc_rst, 1);

        @(posedge clk);
        #1 rst_f = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ret_model = 0;

        run_instr(8, 0, 0, 0);
        run_instr(1, 3, 5, 3);
        run_instr(5, 2, 2, 0);
        run_instr(5, 2, 0, 0);
        run_instr(6, 15, 0, 0);
        run_instr(11, 7, 9, 0);
        run_instr(2, 1, 1, 2);
        run_instr(8, 8, 3, 0);
        run_instr(4, 12, 4, 0);
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 14);
            mm = $urandom_range(0, 15);
            if (op == 8 && $urandom_range(0, 1) == 1) mm = 8;
            st = $urandom_range(0, 15);
            nw = $urandom_range(0, 3);
            run_instr(op, mm, st, nw);
        end
        run_instr(15, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            bus.mem_rdy = ~bus.mem_rdy;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("halt_stays_halted", bus.halted, 1);
        chk("halt_retired_frozen", int'(bus.retired), ret_model);
        chk("halt_no_fetch", bus.ir_load, 0);
        chk("halt_no_pc_write", bus.pc_write, 0);
        mon_en = 1'b0;

        #2 rst_f = 1'b0;
        #1;
        chk("async_rst_halted", bus.halted, 0);
        chk("async_rst_pc_rst", bus.pc_rst, 1);
        chk("async_rst_retired", int'(bus.retired), 0);

        @(posedge clk);
        #1 rst_f = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ret_model = 0;
        run_instr(0, 0, 0, 0);
        run_instr(0, 0, 0, 0);
        str_watch = 1'b1;
        bus.opcode = 4'd2;
        bus.mem_rdy = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("str_wait_retired", int'(bus.retired), 2);
        chk("str_wait_rd_sel", bus.rd_sel, 1);
        chk("str_wait_dm_we", bus.dm_we, 0);
        #2 rst_f = 1'b0;
        #1;
        chk("str_rst_pc_rst", bus.pc_rst, 1);
        chk("str_rst_rd_sel", bus.rd_sel, 0);
        chk("str_rst_retired", int'(bus.retired), 0);
        chk("str_rst_dm_we", bus.dm_we, 0);
        str_watch = 1'b0;
        chk("str_dm_we_never", dm_seen, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
